bcd_display_scanner: RTL
========================

Name: bcd_display_scanner

Overview:
- Consumes the three BCD digits driven by the countdown timer (hundreds/tens/ones) and drives a multiplexed, common-anode 4-digit seven-segment display.
- Captures digits on a load strobe so a digit is never displayed mid-update.
- Scans one digit per refresh slot and blinks the whole display while the timeout flag is asserted.
- Sits between the countdown block and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (must be >= 2)
- BLINK_DIV, 100, digit slots per blink half-period (must be >= 1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- value_three  in  4  hundreds BCD digit
- value_two  in  4  tens BCD digit
- value_one  in  4  ones BCD digit
- load  in  1  capture strobe; samples the three value inputs at the clock edge where load==1
- timeout  in  1  level; 1 = blink display
- seg  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low
- an  out  4  anode enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds; an[3] always 1

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk. While reset==0 at a clk edge, the block sets the following:
  - snapshot registers = 0
  - slot counter = 0, digit index = 0
  - blink counter = 0, blink phase = on
  - seg = 7'b1111111, an = 4'b1111
- Reset mid-scan: reset overrides everything, including load.
- Snapshot:
  - On a clk edge with load==1 (and not reset), snap_three/two/one take the inputs.
  - When load==0, the snapshot holds.
  - If load is tied high, the display follows the inputs with 1 cycle of capture latency.
- Slot counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Terminal = (count == REFRESH_DIV-1).
  - On terminal, digit index advances 0->1->2->0. Index 3 is never reached; if it is reached, the next terminal forces it to 0.
- Output register:
  - seg and an are registered and reflect the index, snapshot and phase of the previous cycle.
  - Total latency from load edge to visible seg is 2 clk cycles, provided the digit is currently selected.
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Non-BCD codes 10-15 display a dash, 0111111.
- Anodes: for index i, an has bit i low and all other bits high, unless the digit is blanked or the phase is off, in which case an = 4'b1111 and seg = 7'b1111111.
- Blink:
  - While timeout==1, the blink counter increments on each slot terminal.
  - When the count reaches BLINK_DIV-1 on a terminal, the counter clears and the phase toggles.
  - While timeout==0, the counter is held at 0 and the phase is forced on. The display is therefore visible within 1 cycle of timeout falling.
  - A rising edge of timeout starts with the phase on, for a full half-period.
- Simultaneous load and slot terminal: the new snapshot and the new index both take effect. The output in the next cycle uses the old snapshot with the old index, per the registered rule above.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds digit is blanked when snap_three==0.
  - Tens digit is blanked when snap_three==0 and snap_two==0.
  - Ones digit is never blanked, so 000 shows a single "0".
  - A non-BCD hundreds digit counts as nonzero.
- Undefined: all three digits always display, including leading zeros. Blink behaviour is unchanged in both cases.

Test Plan:
1. Reset held 3 cycles, then released with load=0 -> during reset, an=1111 and seg=1111111. One cycle after release, an=1110 and seg=1000000 (ones digit "0"). Blanking applies to the other digits.
2. REFRESH_DIV=4, load=1 pulse with 3/5/7 (hundreds/tens/ones) -> an steps 1110 (seg 1111000), 1101 (seg 0010010), 1011 (seg 0110000), each held 4 cycles; the sequence then repeats.
3. LEADING_ZERO_BLANK_EN defined, snapshot 0/0/4 -> only an=1110 slots are lit with seg=0011001. The tens and hundreds slots show an=1111. Without the macro, those slots show "0".
4. Snapshot 0/12/9 -> tens slot shows the dash, 0111111. With blanking enabled, the hundreds slot is blank and the tens slot is not.
5. REFRESH_DIV=4, BLINK_DIV=2, timeout=1 -> display is on for 8 cycles, then an=1111 for 8 cycles, repeating. Dropping timeout during the off phase shows a lit digit on the next cycle.
6. load changes the inputs while load=0 -> display is unchanged. Asserting load together with reset=0 -> snapshot remains 0.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: captures three BCD digits on a load strobe and scans
// them onto a common-anode, active-low, 4-digit seven-segment display.
// The whole display blinks while timeout is high.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module bcd_display_scanner #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value_three,
    input  logic [3:0] value_two,
    input  logic [3:0] value_one,
    input  logic       load,
    input  logic       timeout,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int unsigned SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef enum logic [1:0] {
        DIG_ONES     = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2,
        DIG_UNUSED   = 2'd3
    } digit_t;

    logic [3:0]         snap_three;
    logic [3:0]         snap_two;
    logic [3:0]         snap_one;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase_on;
    logic               slot_term;
    digit_t             digit_q;
    digit_t             digit_d;
    logic [6:0]         seg_d;
    logic [3:0]         an_d;
    logic [3:0]         digit_val;
    logic [3:0]         an_sel;
    logic               blank;

    // Active-low {g,f,e,d,c,b,a} pattern; non-BCD codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign slot_term = (slot_cnt == SLOT_LAST);

    // Snapshot of the countdown digits, updated only on load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            snap_three <= 4'd0;
            snap_two   <= 4'd0;
            snap_one   <= 4'd0;
        end else if (load) begin
            snap_three <= value_three;
            snap_two   <= value_two;
            snap_one   <= value_one;
        end
    end

    // Refresh slot counter, wraps every REFRESH_DIV cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_cnt <= '0;
        end else if (slot_term) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Blink half-period counter and phase; idle (phase on) while timeout is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (!timeout) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (slot_term) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase_on  <= ~phase_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Digit scan state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_q <= DIG_ONES;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Next digit on slot terminal and decode of the currently selected digit.
    always_comb begin
        digit_d   = digit_q;
        digit_val = 4'd0;
        an_sel    = AN_OFF;
        blank     = 1'b0;
        seg_d     = SEG_OFF;
        an_d      = AN_OFF;

        case (digit_q)
            DIG_ONES: begin
                digit_val = snap_one;
                an_sel    = 4'b1110;
                if (slot_term) digit_d = DIG_TENS;
            end
            DIG_TENS: begin
                digit_val = snap_two;
                an_sel    = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
                blank     = (snap_three == 4'd0) && (snap_two == 4'd0);
`endif
                if (slot_term) digit_d = DIG_HUNDREDS;
            end
            DIG_HUNDREDS: begin
                digit_val = snap_three;
                an_sel    = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
                blank     = (snap_three == 4'd0);
`endif
                if (slot_term) digit_d = DIG_ONES;
            end
            default: begin
                blank = 1'b1;
                if (slot_term) digit_d = DIG_ONES;
            end
        endcase

        // A low timeout overrides a stale off phase so the display reappears at once.
        if (!blank && (phase_on || !timeout)) begin
            seg_d = bcd_to_seg(digit_val);
            an_d  = an_sel;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule
